// File: rtl/if_fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and the instruction
// memory/arbiter (slave): request/grant handshake plus a read-data strobe.
interface if_fetch_unit_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. Owns the PC, fetches one word at a time over
// the req/gnt/rvalid instruction bus and holds it for the IF/ID register
// until ctrl lets the PC stage advance. Redirects come from ctrl (flush,
// highest priority) and from ID (taken branch, latched if it arrives while
// the fetch unit cannot advance).
// Optional feature: define FETCH_ALIGN_CHECK_EN to add fetch_adel_o and
// suppress bus requests for misaligned PCs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [31:0]         new_pc,
  input  logic                branch_flag_i,
  input  logic [31:0]         branch_target_address_i,
  if_fetch_unit_if.master     ibus,
  output logic [31:0]         pc_o,
  output logic [31:0]         inst_o,
  output logic                stallreq_from_if_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                fetch_adel_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,   // one bubble cycle before (re)issuing a request
    S_REQ,    // request on the bus, waiting for grant
    S_WAIT,   // granted, waiting for read data
    S_HOLD,   // word buffered and presented to IF/ID
    S_DRAIN   // redirected while a read was outstanding; swallow its data
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic        pend_br_q, pend_br_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        req_w;
  logic        advance_w;

  // Only the PC-stage bit of the stall vector matters to this unit.
  logic        unused_stall;
  assign unused_stall = ^stall[5:1];

`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_q, adel_d;
  logic misaligned_w;

  assign misaligned_w    = (pc_q[1:0] != 2'b00);
  assign req_w           = (state_q == S_REQ) && !misaligned_w;
  assign ibus.ibus_addr_o = pc_q;
  assign fetch_adel_o    = adel_q;
`else
  assign req_w           = (state_q == S_REQ);
  assign ibus.ibus_addr_o = {pc_q[31:2], 2'b00};
`endif

  assign ibus.ibus_req_o  = req_w;
  assign advance_w        = (state_q == S_HOLD) && !stall[0];

  // The held word is the only thing IF/ID ever sees; everything else reads as a bubble.
  assign stallreq_from_if_o = !buf_valid_q;
  assign inst_o             = buf_valid_q ? buf_q : 32'h0;
  assign pc_o               = pc_q;

  // Next-state logic: flush first, then branch latching and the fetch sequence.
  always_comb begin
    // NOTE: every variable gets its hold value before any branch, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    pend_br_d   = pend_br_q;
    pend_tgt_d  = pend_tgt_q;
`ifdef FETCH_ALIGN_CHECK_EN
    adel_d      = adel_q;
`endif

    if (flush) begin
      pc_d        = new_pc;
      buf_valid_d = 1'b0;
      pend_br_d   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_d      = 1'b0;
`endif
      unique case (state_q)
        // A grant in the same cycle leaves a read in flight that must be drained.
        S_REQ:   state_d = (req_w && ibus.ibus_gnt_i) ? S_DRAIN : S_IDLE;
        S_WAIT:  state_d = ibus.ibus_rvalid_i ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = ibus.ibus_rvalid_i ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      // A branch resolved while we cannot advance is remembered until we can.
      if (branch_flag_i && !advance_w) begin
        pend_br_d  = 1'b1;
        pend_tgt_d = branch_target_address_i;
      end

      unique case (state_q)
        S_IDLE: state_d = S_REQ;

        S_REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (misaligned_w) begin
            buf_d       = 32'h0;
            buf_valid_d = 1'b1;
            adel_d      = 1'b1;
            state_d     = S_HOLD;
          end else if (ibus.ibus_gnt_i) begin
            state_d = S_WAIT;
          end
`else
          if (ibus.ibus_gnt_i) state_d = S_WAIT;
`endif
        end

        S_WAIT: begin
          if (ibus.ibus_rvalid_i) begin
            buf_d       = ibus.ibus_rdata_i;
            buf_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end

        S_HOLD: begin
          if (advance_w) begin
            // A branch arriving in the advance cycle is newer than any latched one.
            if (branch_flag_i)  pc_d = branch_target_address_i;
            else if (pend_br_q) pc_d = pend_tgt_q;
            else                pc_d = pc_q + 32'd4;
            buf_valid_d = 1'b0;
            pend_br_d   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_d      = 1'b0;
`endif
            state_d     = S_REQ;
          end
        end

        S_DRAIN: begin
          if (ibus.ibus_rvalid_i) state_d = S_REQ;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset to the boot vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      buf_q       <= 32'h0;
      buf_valid_q <= 1'b0;
      pend_br_q   <= 1'b0;
      pend_tgt_q  <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      pend_br_q   <= pend_br_d;
      pend_tgt_q  <= pend_tgt_d;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q      <= adel_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a bus responder serves instruction reads, the
// stimulus process pushes expected fetch addresses and held words into
// queues, and a monitor pops and compares them as the DUT produces them.
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_flag;
  logic [31:0] br_tgt;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stallreq;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        adel;
`endif

  logic        gnt_en;
  int          rv_lat;
  bit          exp_sr1 = 1'b0;
  bit          gap_chk = 1'b0;

  logic [31:0] exp_addr_q[$];
  word_t       exp_word_q[$];

  int total = 0;
  int bad   = 0;

  if_fetch_unit_if bus();

  assign bus.ibus_gnt_i = bus.ibus_req_o & gnt_en;

  if_fetch_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (br_flag),
    .branch_target_address_i (br_tgt),
    .ibus                    (bus),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .stallreq_from_if_o      (stallreq)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_adel_o            (adel)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    word_t w;
    w.pc   = a;
    w.inst = mem_word(a);
    exp_addr_q.push_back(a);
    exp_word_q.push_back(w);
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] inst);
    word_t w;
    w.pc   = a;
    w.inst = inst;
    exp_word_q.push_back(w);
  endtask

  // Waits for a granted request (returns at the negedge of the grant cycle).
  task automatic wait_gnt();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.ibus_req_o && bus.ibus_gnt_i) && n < 200);
    check("wait_gnt_timeout", 32'(n >= 200), 32'd0);
  endtask

  // Waits for the next entry into a held word (returns at its first negedge).
  task automatic wait_hold();
    int n;
    n = 0;
    @(negedge clk);
    while (!stallreq && n < 200) begin @(negedge clk); n++; end
    while (stallreq && n < 200) begin @(negedge clk); n++; end
    check("wait_hold_timeout", 32'(n >= 200), 32'd0);
  endtask

  // Bus responder: one rvalid per grant, rv_lat cycles after it.
  initial begin
    logic [31:0] g_addr;
    int          g_cnt;
    g_addr = 32'h0;
    g_cnt  = 0;
    bus.ibus_rvalid_i = 1'b0;
    bus.ibus_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) g_cnt = 0;
      else if (bus.ibus_req_o && bus.ibus_gnt_i) begin
        g_addr = bus.ibus_addr_o;
        g_cnt  = rv_lat;
      end
      @(posedge clk);
      #1;
      bus.ibus_rvalid_i = 1'b0;
      bus.ibus_rdata_i  = 32'h0;
      if (rst) g_cnt = 0;
      else if (g_cnt > 0) begin
        g_cnt--;
        if (g_cnt == 0) begin
          bus.ibus_rvalid_i = 1'b1;
          bus.ibus_rdata_i  = mem_word(g_addr);
        end
      end
    end
  end

  // Monitor: compares bus requests and held words against the queues.
  initial begin
    word_t       w;
    logic [31:0] last_pc, last_inst;
    bit          hold_prev;
    int          cyc, last_gnt;
    last_pc   = 32'h0;
    last_inst = 32'h0;
    hold_prev = 1'b0;
    cyc       = 0;
    last_gnt  = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rst_req", 32'(bus.ibus_req_o), 32'd0);
        check("rst_addr", bus.ibus_addr_o, 32'hBFC0_0000);
        check("rst_pc_o", pc_o, 32'hBFC0_0000);
        check("rst_inst", inst_o, 32'h0);
        check("rst_stallreq", 32'(stallreq), 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_adel", 32'(adel), 32'd0);
`endif
        hold_prev = 1'b0;
        last_gnt  = -1;
      end else begin
        if (stallreq) check("inst_zero_when_stalled", inst_o, 32'h0);
        if (exp_sr1) check("stallreq_during_flush", 32'(stallreq), 32'd1);

        if (bus.ibus_req_o && bus.ibus_gnt_i) begin
          if (exp_addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got addr=%08h expected no request", bus.ibus_addr_o);
          end else begin
            check("req_addr", bus.ibus_addr_o, exp_addr_q.pop_front());
          end
          if (gap_chk && last_gnt >= 0) check("fetch_gap", 32'(cyc - last_gnt), 32'd3);
          last_gnt = cyc;
        end

        if (!stallreq && !hold_prev) begin
          if (exp_word_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got pc=%08h inst=%08h expected none", pc_o, inst_o);
          end else begin
            w = exp_word_q.pop_front();
            check("word_pc", pc_o, w.pc);
            check("word_inst", inst_o, w.inst);
          end
          last_pc   = pc_o;
          last_inst = inst_o;
        end else if (!stallreq && hold_prev) begin
          check("stalled_pc_const", pc_o, last_pc);
          check("stalled_inst_const", inst_o, last_inst);
          check("stalled_no_req", 32'(bus.ibus_req_o), 32'd0);
        end
        hold_prev = !stallreq;
      end
    end
  end

  // Directed stimulus.
  initial begin
    logic [31:0] t6_pc;
    rst     = 1'b1;
    stall   = 6'b0;
    flush   = 1'b0;
    new_pc  = 32'h0;
    br_flag = 1'b0;
    br_tgt  = 32'h0;
    gnt_en  = 1'b1;
    rv_lat  = 1;
`ifdef FETCH_ALIGN_CHECK_EN
    t6_pc = 32'hBFC0_0382;
`else
    t6_pc = 32'hBFC0_0390;
`endif

    exp_addr_q.push_back(32'hBFC0_0000);       // aborted by reset
    push_fetch(32'hBFC0_0000);
    push_fetch(32'hBFC0_0004);
    push_fetch(32'hBFC0_0008);
    push_fetch(32'hBFC0_000C);
    push_fetch(32'h8000_0100);
    exp_addr_q.push_back(32'h8000_0104);       // flushed, data discarded
    push_fetch(32'hBFC0_0380);
`ifdef FETCH_ALIGN_CHECK_EN
    push_word(t6_pc, 32'h0);
`else
    push_fetch(t6_pc);
`endif
    push_fetch(32'hFFFF_FFFC);
    push_fetch(32'h0000_0000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted mid-WAIT takes effect without a clock edge.
    wait_gnt();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Straight-line fetch, one word every 3 cycles; stall on the third.
    gap_chk = 1'b1;
    wait_hold();
    wait_hold();
    wait_hold();
    stall   = 6'b000011;
    gap_chk = 1'b0;

    // Hold for 5 cycles, then continue at pc+4.
    repeat (5) @(posedge clk);
    #1 stall = 6'b0;

    // Branch pulsed during WAIT redirects the fetch after the current word.
    wait_gnt();
    @(posedge clk); #1;
    br_flag = 1'b1;
    br_tgt  = 32'h8000_0100;
    @(posedge clk); #1;
    br_flag = 1'b0;
    br_tgt  = 32'h0;

    // Flush in WAIT with the read data arriving two cycles later.
    wait_gnt();
    @(posedge clk); #1;
    rv_lat = 3;
    wait_gnt();
    @(posedge clk); #1;
    flush   = 1'b1;
    new_pc  = 32'hBFC0_0380;
    exp_sr1 = 1'b1;
    @(posedge clk); #1;
    flush  = 1'b0;
    rv_lat = 1;
    wait_gnt();
    exp_sr1 = 1'b0;

    // Flush in REQ without a grant: request drops for a cycle.
    wait_hold();
    gnt_en = 1'b0;
    @(posedge clk); #1;
    check("t6_req_pending", 32'(bus.ibus_req_o), 32'd1);
    check("t6_req_addr", bus.ibus_addr_o, 32'hBFC0_0384);
    flush  = 1'b1;
    new_pc = t6_pc;
    @(posedge clk); #1;
    flush  = 1'b0;
    gnt_en = 1'b1;
    check("t6_req_dropped", 32'(bus.ibus_req_o), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    @(posedge clk); #1;
    check("t6_misaligned_no_req", 32'(bus.ibus_req_o), 32'd0);
`endif
    wait_hold();
    stall = 6'b000011;
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6_adel_set", 32'(adel), 32'd1);
`endif

    // Flush from a stalled HOLD to the top of memory; pc+4 wraps to zero.
    @(posedge clk); #1;
    flush  = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    stall  = 6'b0;
    @(posedge clk); #1;
    flush = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("t7_adel_cleared", 32'(adel), 32'd0);
`endif
    wait_hold();
    wait_hold();
    stall = 6'b000011;

    repeat (4) @(posedge clk);
    #1;
    check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    check("word_queue_empty", 32'(exp_word_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
